// File: rtl/inst_encoder.sv
// Packs instruction field bundles into 32-bit VMIPS words and writes them to
// instruction memory at consecutive addresses using a write/ack handshake.
module inst_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                ill_q, ill_d;
    logic                ovf_q, ovf_d;
    logic                last_q, last_d;

    logic [31:0]         enc_word;
    logic                enc_legal;
    logic [ADDR_W:0]     count_inc;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (in_fmt)
            3'd0:    enc_word = {6'b0, in_rs, in_rt, in_rd, in_shamt, in_funct};
            3'd1:    enc_word = {in_op, in_rs, in_rt, in_imm};
            3'd2:    enc_word = {in_op, in_target};
            // Vector-imm leaves bit 10 clear so rd sits where the decoder expects it.
            3'd3:    enc_word = {in_op, in_rs, in_rt, in_rd, 1'b0, in_imm[9:0]};
            3'd4:    enc_word = {in_op, in_rs, in_rt, in_rd, in_shamt, in_funct};
            default: enc_legal = 1'b0;
        endcase
        if (in_fmt != 3'd0 && in_op == 6'b0) begin
            enc_legal = 1'b0;
        end
    end

    assign count_inc = count_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        ill_d   = ill_q;
        ovf_d   = ovf_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCEPT;
                    addr_d  = '0;
                    count_d = '0;
                    ill_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            S_ACCEPT: begin
                if (in_valid) begin
                    if (enc_legal) begin
                        wdata_d = enc_word;
                        last_d  = in_last;
                        state_d = S_WRITE;
                    end else begin
                        ill_d = 1'b1;
                        if (in_last) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    addr_d  = addr_q + ADDR_ONE;
                    count_d = count_inc;
                    if (last_q) begin
                        state_d = S_DONE;
                    end else if (count_inc == DEPTH_C) begin
                        ovf_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCEPT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            ill_q   <= 1'b0;
            ovf_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            ill_q   <= ill_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
        end
    end

    assign in_ready     = (state_q == S_ACCEPT);
    assign mem_we       = (state_q == S_WRITE);
    assign busy         = (state_q == S_ACCEPT) || (state_q == S_WRITE);
    assign done         = (state_q == S_DONE);
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign word_count   = count_q;
    assign err_illegal  = ill_q;
    assign err_overflow = ovf_q;

endmodule
